// File: rtl/mem_bus_sched.sv
// mem_bus_sched: arbitrates the byte-wide external memory bus between the
// instruction-fetch port (IF, word reads) and the data port (DM, 1/2/4-byte
// loads and stores). Each access becomes a run of byte beats; reads are
// pipelined across the one-cycle memory latency and assembled little-endian.
//
// Handshake: a requester raises *_req (level) with its command fields valid;
// the command is latched on the grant edge; completion is a single-cycle
// *_done pulse with *_rdata valid in that cycle; req must fall in the done
// cycle or the one after, otherwise it counts as a new request.
//
// dbg_state_o encoding: 0 = IDLE, 1 = IF_RD, 2 = DM_RD, 3 = DM_WR.
module mem_bus_sched #(
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  IDLE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [2:0]        dm_len,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_done,
  output logic [31:0]       dm_rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_IF_RD = 2'd1,
    S_DM_RD = 2'd2,
    S_DM_WR = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        len_q, len_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        iss_q, iss_d;     // beats issued so far
  logic [2:0]        cap_q, cap_d;     // bytes captured so far
  logic              pres_q, pres_d;   // mem_a carries a valid read beat this cycle
  logic              vld_q, vld_d;     // mem_din carries byte cap_q this cycle
  logic [31:0]       asm_q, asm_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;
  logic              if_done_q, if_done_d;
  logic              dm_done_q, dm_done_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       dm_rdata_q, dm_rdata_d;

  logic              last_cap;
  logic              is_rd;
  logic [31:0]       asm_next;
  logic [7:0]        wr_byte;
  logic [ADDR_W-1:0] issue_a;

  // Any length other than 1 or 2 is a full word.
  function automatic logic [2:0] decode_len(input logic [2:0] len);
    case (len)
      3'd1:    return 3'd1;
      3'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Next-state, beat issue, byte capture and completion.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    wdata_d    = wdata_q;
    iss_d      = iss_q;
    cap_d      = cap_q;
    pres_d     = pres_q;
    vld_d      = vld_q;
    asm_d      = asm_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    if_done_d  = 1'b0;
    dm_done_d  = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    last_cap   = 1'b0;
    is_rd      = (state_q == S_IF_RD) || (state_q == S_DM_RD);
    asm_next   = asm_q;
    asm_next[{cap_q[1:0], 3'b000} +: 8] = mem_din;
    wr_byte    = wdata_q[{iss_q[1:0], 3'b000} +: 8];
    issue_a    = addr_q + ADDR_W'(iss_q);

    case (state_q)
      S_IDLE: begin
        if (rdy && dm_req) begin
          addr_d  = dm_addr;
          len_d   = decode_len(dm_len);
          wdata_d = dm_wdata;
          asm_d   = '0;
          cap_d   = 3'd0;
          iss_d   = 3'd1;
          mem_a_d = dm_addr;
          vld_d   = 1'b0;
          if (dm_we) begin
            state_d    = S_DM_WR;
            mem_dout_d = dm_wdata[7:0];
            mem_wr_d   = 1'b1;
            pres_d     = 1'b0;
          end else begin
            state_d = S_DM_RD;
            pres_d  = 1'b1;
          end
        end else if (rdy && if_req && !if_flush) begin
          state_d = S_IF_RD;
          addr_d  = if_addr;
          len_d   = 3'd4;
          asm_d   = '0;
          cap_d   = 3'd0;
          iss_d   = 3'd1;
          mem_a_d = if_addr;
          pres_d  = 1'b1;
          vld_d   = 1'b0;
        end
      end

      S_DM_WR: begin
        if (rdy) begin
          if (iss_q < len_q) begin
            mem_a_d    = issue_a;
            mem_dout_d = wr_byte;
            iss_d      = iss_q + 3'd1;
          end else begin
            state_d    = S_IDLE;
            mem_a_d    = IDLE_ADDR;
            mem_dout_d = 8'h00;
            mem_wr_d   = 1'b0;
            iss_d      = 3'd0;
            dm_done_d  = 1'b1;
          end
        end
      end

      default: begin
        if (rdy && vld_q) begin
          cap_d = cap_q + 3'd1;
          asm_d = asm_next;
          if (cap_q == len_q - 3'd1) last_cap = 1'b1;
        end
        if (is_rd && last_cap) begin
          // Final byte: complete even if a flush arrives in the same cycle.
          state_d = S_IDLE;
          mem_a_d = IDLE_ADDR;
          pres_d  = 1'b0;
          vld_d   = 1'b0;
          iss_d   = 3'd0;
          cap_d   = 3'd0;
          if (state_q == S_IF_RD) begin
            if_done_d  = 1'b1;
            if_rdata_d = asm_next;
          end else begin
            dm_done_d  = 1'b1;
            dm_rdata_d = asm_next;
          end
        end else if (state_q == S_IF_RD && if_flush) begin
          state_d = S_IDLE;
          mem_a_d = IDLE_ADDR;
          pres_d  = 1'b0;
          vld_d   = 1'b0;
          iss_d   = 3'd0;
          cap_d   = 3'd0;
        end else if (rdy) begin
          vld_d = pres_q;
          if (iss_q < len_q) begin
            mem_a_d = issue_a;
            iss_d   = iss_q + 3'd1;
            pres_d  = 1'b1;
          end else begin
            mem_a_d = IDLE_ADDR;
            pres_d  = 1'b0;
          end
        end else begin
          // Paused: beats in flight are lost, so restart issue at the first
          // byte not yet captured.
          pres_d = 1'b0;
          vld_d  = 1'b0;
          iss_d  = cap_q;
        end
      end
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= 3'd0;
      wdata_q    <= '0;
      iss_q      <= 3'd0;
      cap_q      <= 3'd0;
      pres_q     <= 1'b0;
      vld_q      <= 1'b0;
      asm_q      <= '0;
      mem_a_q    <= IDLE_ADDR;
      mem_dout_q <= 8'h00;
      mem_wr_q   <= 1'b0;
      if_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      wdata_q    <= wdata_d;
      iss_q      <= iss_d;
      cap_q      <= cap_d;
      pres_q     <= pres_d;
      vld_q      <= vld_d;
      asm_q      <= asm_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      if_done_q  <= if_done_d;
      dm_done_q  <= dm_done_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  // Outputs; a pause suppresses the write strobe without touching state.
  always_comb begin
    mem_a       = mem_a_q;
    mem_dout    = mem_dout_q;
    mem_wr      = mem_wr_q & rdy;
    if_done     = if_done_q;
    dm_done     = dm_done_q;
    if_rdata    = if_rdata_q;
    dm_rdata    = dm_rdata_q;
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_mem_bus_sched.sv
// tb_mem_bus_sched: directed scenarios followed by randomized accesses
// checked against a byte-array memory model.
module tb_mem_bus_sched;

  localparam logic [31:0] IDLE_A = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_flush = 1'b0;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [2:0]  dm_len = 3'd0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [7:0]  mem_din;
  wire         if_done, dm_done, mem_wr;
  wire  [31:0] if_rdata, dm_rdata, mem_a;
  wire  [7:0]  mem_dout;
  wire  [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int if_done_cnt = 0;
  int dm_done_cnt = 0;
  int io_cnt = 0;
  int oob_cnt = 0;
  logic        chk_en = 1'b0;
  logic [31:0] win_lo = '0;
  logic [31:0] win_len = 32'd4;

  logic [7:0] mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  mem_bus_sched #(.ADDR_W(32), .IDLE_ADDR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_len(dm_len), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .dbg_state_o(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Initial memory image: a few fixed bytes for directed tests, hash elsewhere.
  function automatic logic [7:0] init_byte(input logic [31:0] a);
    case (a)
      32'h100:   return 8'h13;
      32'h101:   return 8'h05;
      32'h102:   return 8'h00;
      32'h103:   return 8'h00;
      32'h300:   return 8'h78;
      32'h301:   return 8'h56;
      32'h302:   return 8'h34;
      32'h303:   return 8'h12;
      32'h1500:  return 8'hA5;
      32'h1501:  return 8'h3C;
      32'h30000: return 8'h41;
      default:   return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [7:0] bus_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  // External memory, done counters and bus-address monitors.
  always @(posedge clk) begin
    if (mem_wr) mem[mem_a] = mem_dout;
    mem_din <= bus_rd(mem_a);
    if (if_done) if_done_cnt++;
    if (dm_done) dm_done_cnt++;
    if (rdy && mem_a == 32'h30000) io_cnt++;
    if (chk_en && rdy && mem_a != IDLE_A && (mem_a - win_lo) >= win_len) oob_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit is_if, input int budget, input bit rnd_rdy,
                           output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    for (int i = 1; i <= budget; i++) begin
      step();
      if ((is_if ? if_done : dm_done) === 1'b1) begin
        cycles = i;
        ok = 1'b1;
        break;
      end
      if (rnd_rdy) rdy = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin : main
    int c, d0, i0, io0, op, raw, len;
    bit ok, pz;
    logic [31:0] addr, wd, expv, hold_a;

    // Reset values, before any clock edge
    #3;
    check("rst_state", dbg_state, 2'd0);
    check("rst_mem_a", mem_a, IDLE_A);
    check("rst_mem_wr", mem_wr, 1'b0);
    check("rst_mem_dout", mem_dout, 8'h00);
    check("rst_dones", {if_done, dm_done}, 2'b00);
    check("rst_rdata", {if_rdata, dm_rdata}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // IF fetch of 0x100
    if_addr = 32'h100; if_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k <= 4) check($sformatf("if_mem_a_c%0d", k), mem_a, 32'h100 + k - 1);
      if (k == 5) check("if_done_early", if_done, 1'b0);
      if (k == 6) begin
        check("if_done_c6", if_done, 1'b1);
        check("if_rdata", if_rdata, 32'h00000513);
        if_req = 1'b0;
      end
    end

    // Store word 0xDEADBEEF at 0x2000
    step();
    dm_we = 1'b1; dm_len = 3'd4; dm_addr = 32'h2000; dm_wdata = 32'hDEADBEEF; dm_req = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k <= 4) begin
        check($sformatf("st_wr_c%0d", k), mem_wr, 1'b1);
        check($sformatf("st_a_c%0d", k), mem_a, 32'h2000 + k - 1);
        check($sformatf("st_dout_c%0d", k), mem_dout, (32'hDEADBEEF >> (8 * (k - 1))) & 32'hFF);
      end else begin
        check("st_done_c5", dm_done, 1'b1);
        check("st_wr_off", mem_wr, 1'b0);
        dm_req = 1'b0; dm_we = 1'b0;
      end
    end
    check("st_mem", {bus_rd(32'h2003), bus_rd(32'h2002), bus_rd(32'h2001), bus_rd(32'h2000)},
          32'hDEADBEEF);

    // Simultaneous IF and DM: DM first, single I/O byte read
    step();
    io0 = io_cnt; i0 = if_done_cnt;
    if_addr = 32'h100; if_req = 1'b1;
    dm_we = 1'b0; dm_len = 3'd1; dm_addr = 32'h30000; dm_req = 1'b1;
    wait_done(1'b0, 20, 1'b0, c, ok);
    check("sim_dm_done_seen", ok, 1'b1);
    check("sim_dm_latency", c, 3);
    check("sim_dm_rdata", dm_rdata, 32'h00000041);
    check("sim_no_if_yet", if_done_cnt - i0, 0);
    dm_req = 1'b0;
    step();
    check("sim_if_grant_a", mem_a, 32'h100);
    check("sim_if_grant_st", dbg_state, 2'd1);
    wait_done(1'b1, 20, 1'b0, c, ok);
    check("sim_if_done_seen", ok, 1'b1);
    check("sim_if_rdata", if_rdata, 32'h00000513);
    if_req = 1'b0;
    check("sim_io_once", io_cnt - io0, 1);

    // Flush mid-fetch with a DM load queued behind it
    step();
    i0 = if_done_cnt;
    if_addr = 32'h200; if_req = 1'b1;
    step();
    dm_we = 1'b0; dm_len = 3'd2; dm_addr = 32'h1500; dm_req = 1'b1;
    step();
    step();
    if_flush = 1'b1; if_req = 1'b0;
    step();
    check("fl_state_idle", dbg_state, 2'd0);
    check("fl_mem_a_idle", mem_a, IDLE_A);
    check("fl_no_if_done", if_done, 1'b0);
    if_flush = 1'b0;
    step();
    check("fl_dm_grant_a", mem_a, 32'h1500);
    check("fl_dm_grant_st", dbg_state, 2'd2);
    wait_done(1'b0, 20, 1'b0, c, ok);
    check("fl_dm_done_seen", ok, 1'b1);
    check("fl_dm_rdata", dm_rdata, 32'h00003CA5);
    dm_req = 1'b0;
    step();
    check("fl_if_done_none", if_done_cnt - i0, 0);

    // Pause during an IF read (rdy low in cycles 2-4)
    step();
    if_addr = 32'h300; if_req = 1'b1;
    step();
    step();
    rdy = 1'b0;
    hold_a = mem_a;
    for (int k = 2; k <= 4; k++) begin
      check($sformatf("pz_wr_c%0d", k), mem_wr, 1'b0);
      check($sformatf("pz_state_c%0d", k), dbg_state, 2'd1);
      check($sformatf("pz_hold_a_c%0d", k), mem_a, hold_a);
      step();
    end
    rdy = 1'b1;
    wait_done(1'b1, 30, 1'b0, c, ok);
    check("pz_done_seen", ok, 1'b1);
    check("pz_delayed", (5 + c) >= 9, 1'b1);
    check("pz_rdata", if_rdata, 32'h12345678);
    if_req = 1'b0;

    // Async reset in the middle of a store
    step();
    d0 = dm_done_cnt;
    dm_we = 1'b1; dm_len = 3'd4; dm_addr = 32'h2100; dm_wdata = 32'h11223344; dm_req = 1'b1;
    step();
    step();
    check("ar_wr_before", mem_wr, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_wr", mem_wr, 1'b0);
    check("ar_mem_a", mem_a, IDLE_A);
    check("ar_dout", mem_dout, 8'h00);
    check("ar_state", dbg_state, 2'd0);
    check("ar_dones", {if_done, dm_done}, 2'b00);
    check("ar_rdata", {if_rdata, dm_rdata}, 64'h0);
    dm_req = 1'b0; dm_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) step();
    check("ar_no_done", dm_done_cnt - d0, 0);

    // Randomized accesses against the memory model
    chk_en = 1'b1;
    for (int t = 0; t < 40; t++) begin
      op   = $urandom_range(0, 2);     // 0 = IF read, 1 = DM load, 2 = DM store
      addr = 32'h4000 + $urandom_range(0, 4095);
      if (t % 10 == 9) addr = 32'hFFFF_FFFD;
      raw  = $urandom_range(0, 7);
      len  = (op == 0) ? 4 : (raw == 1) ? 1 : (raw == 2) ? 2 : 4;
      wd   = $urandom;
      pz   = ($urandom_range(0, 1) == 1);
      win_lo = addr;
      win_len = len;
      expv = '0;
      for (int k = 0; k < len; k++) expv |= 32'(ref_rd(addr + k)) << (8 * k);
      step();
      if (op == 0) begin
        if_addr = addr; if_req = 1'b1;
      end else begin
        dm_we = (op == 2); dm_len = raw[2:0]; dm_addr = addr; dm_wdata = wd; dm_req = 1'b1;
      end
      if (pz) rdy = ($urandom_range(0, 3) != 0);
      wait_done(op == 0, 200, pz, c, ok);
      if_req = 1'b0; dm_req = 1'b0; rdy = 1'b1;
      check($sformatf("rnd%0d_done_seen", t), ok, 1'b1);
      if (!pz) check($sformatf("rnd%0d_latency", t), c, (op == 2) ? len + 1 : len + 2);
      if (op == 0) check($sformatf("rnd%0d_if_rdata", t), if_rdata, expv);
      if (op == 1) check($sformatf("rnd%0d_dm_rdata", t), dm_rdata, expv);
      if (op == 2) begin
        for (int k = 0; k < len; k++) ref_mem[addr + k] = wd[8 * k +: 8];
        for (int k = 0; k < len; k++)
          check($sformatf("rnd%0d_mem_b%0d", t, k), bus_rd(addr + k), ref_rd(addr + k));
      end
      step();
      check($sformatf("rnd%0d_pulse_1cyc", t), {if_done, dm_done}, 2'b00);
    end
    chk_en = 1'b0;
    check("rnd_no_stray_beats", oob_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
